pixel_writer: RTL and testbench

Consumer end of the rasterizer pixel stream. Accepts one pixel per cycle on the `pixel_valid/pixel_x/pixel_y/pixel_color` interface, which has no backpressure. Buffers accepted pixels in a FIFO and converts (x, y) to a linear framebuffer byte address. Issues valid/ready word writes toward the memory/AXI write adapter, and signals flush completion after the rasterizer's `done` once every buffered pixel has been written.

---
 rtl/pixel_writer.sv | 134 +++++++++++++
 tb/tb_pixel_writer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// Rasterizer pixel sink: clips, buffers and turns (x,y) into framebuffer byte writes.
// Latency 2 cycles pixel->mem_wr_valid; pixel input has no backpressure, so a full FIFO drops and flags overflow.
module pixel_writer #(
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel_valid,
  input  logic [31:0] pixel_x,
  input  logic [31:0] pixel_y,
  input  logic [31:0] pixel_color,
  input  logic        rast_done,
  input  logic [31:0] fb_base,
  output logic        mem_wr_valid,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_ready,
  output logic        busy,
  output logic        flush_done,
  output logic        overflow,
  output logic        clip_drop,
  input  logic        clear_err
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] W32     = 32'(FB_WIDTH);
  localparam logic [31:0] H32     = 32'(FB_HEIGHT);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FLUSH} state_t;

  logic [63:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        vld_q, vld_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  state_t      state_q, state_d;
  logic        flush_q, flush_d;
  logic        ovf_q, ovf_d, clip_q, clip_d;

  logic        fifo_empty, fifo_full, in_range, push, pop;
  logic [63:0] head;
  logic [31:0] head_x, head_y, lin, head_addr;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_range   = (pixel_x < W32) && (pixel_y < H32);
  assign pop        = !fifo_empty && (!vld_q || mem_wr_ready);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = pixel_valid && in_range && (!fifo_full || pop);

  assign head      = fifo_mem[rd_ptr_q[AW-1:0]];
  assign head_x    = {16'b0, head[63:48]};
  assign head_y    = {16'b0, head[47:32]};
  assign lin       = head_y * W32 + head_x;
  assign head_addr = fb_base + (lin << 2);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    addr_d   = addr_q;
    data_d   = data_q;
    state_d  = state_q;
    ovf_d    = ovf_q;
    clip_d   = clip_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      vld_d    = 1'b1;
      addr_d   = head_addr;
      data_d   = head[31:0];
    end else if (mem_wr_ready) begin
      vld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE:  if (rast_done) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !vld_q && !push) state_d = ST_FLUSH;
      ST_FLUSH: state_d = rast_done ? ST_DRAIN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    flush_d = (state_d == ST_FLUSH);

    if (clear_err) begin
      ovf_d  = 1'b0;
      clip_d = 1'b0;
    end else begin
      if (pixel_valid && in_range && !push) ovf_d  = 1'b1;
      if (pixel_valid && !in_range)         clip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      state_q  <= ST_IDLE;
      flush_q  <= 1'b0;
      ovf_q    <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      state_q  <= state_d;
      flush_q  <= flush_d;
      ovf_q    <= ovf_d;
      clip_q   <= clip_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {pixel_x[15:0], pixel_y[15:0], pixel_color};
  end

  assign mem_wr_valid = vld_q;
  assign mem_wr_addr  = addr_q;
  assign mem_wr_data  = data_q;
  assign flush_done   = flush_q;
  assign overflow     = ovf_q;
  assign clip_drop    = clip_q;
  assign busy         = !fifo_empty || vld_q || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: stimulus pushes expected writes, a negedge monitor checks them.
module tb_pixel_writer;
  localparam int FB_WIDTH   = 640;
  localparam int FB_HEIGHT  = 480;
  localparam int FIFO_DEPTH = 16;

  logic        clk, rst_n;
  logic        pixel_valid, rast_done, mem_wr_ready, clear_err;
  logic [31:0] pixel_x, pixel_y, pixel_color, fb_base;
  logic        mem_wr_valid, busy, flush_done, overflow, clip_drop;
  logic [31:0] mem_wr_addr, mem_wr_data;

  pixel_writer #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
    .rast_done(rast_done), .fb_base(fb_base),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .busy(busy), .flush_done(flush_done),
    .overflow(overflow), .clip_drop(clip_drop), .clear_err(clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  int pushed = 0, hs_cnt = 0, flush_cnt = 0;
  logic exp_ovf = 1'b0, exp_clip = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_addr(input logic [31:0] x, input logic [31:0] y);
    longint a;
    a = longint'(fb_base) + (longint'(y) * FB_WIDTH + longint'(x)) * 4;
    return a[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: in-flight capacity is FIFO_DEPTH plus the output register.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
    pixel_valid = 1'b1; pixel_x = x; pixel_y = y; pixel_color = c;
    if (!(x < FB_WIDTH && y < FB_HEIGHT)) exp_clip = 1'b1;
    else if (mem_wr_ready || (pushed - hs_cnt) < FIFO_DEPTH + 1) begin
      exp_q.push_back({ref_addr(x, y), c});
      pushed++;
    end else exp_ovf = 1'b1;
    step();
    pixel_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) step();
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    logic [63:0] hd;
    if (mem_wr_valid) begin
      if (exp_q.size() == 0) chk("unexpected_write", {mem_wr_addr, mem_wr_data}, 64'd0);
      else begin
        hd = exp_q[0];
        chk("wr_addr", 64'(mem_wr_addr), 64'(hd[63:32]));
        chk("wr_data", 64'(mem_wr_data), 64'(hd[31:0]));
        if (mem_wr_ready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
    if (flush_done) flush_cnt++;
  end

  initial begin
    int f0, h0;
    logic got;
    logic [31:0] rx, ry;
    rst_n = 1'b1; pixel_valid = 0; pixel_x = 0; pixel_y = 0; pixel_color = 0;
    rast_done = 0; mem_wr_ready = 0; clear_err = 0; fb_base = 32'h1000_0000;
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_outputs", {59'd0, mem_wr_valid, busy, flush_done, overflow, clip_drop}, 64'd0);
    chk("rst_addr_data", {mem_wr_addr, mem_wr_data}, 64'd0);
    rst_n = 1'b1;
    step();

    // Single pixel, latency and flush
    mem_wr_ready = 1'b1;
    send(3, 2, 32'hFF00FF00);
    chk("lat_valid_early", 64'(mem_wr_valid), 64'd0);
    step();
    chk("lat_valid", 64'(mem_wr_valid), 64'd1);
    chk("s2_addr", 64'(mem_wr_addr), 64'h1000_140C);
    f0 = flush_cnt;
    rast_done = 1'b1; step(); rast_done = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (flush_done) begin
        got = 1'b1;
        chk("busy_at_flush", 64'(busy), 64'd0);
      end
    end
    chk("s2_flush_seen", 64'(got), 64'd1);
    repeat (3) step();
    chk("s2_flush_once", 64'(flush_cnt - f0), 64'd1);

    // Full-rate raster stream
    h0 = hs_cnt;
    for (int y = 5; y <= 7; y++)
      for (int x = 10; x <= 13; x++) send(x, y, 32'hC0DE_0000 + 32'(y * 16 + x));
    step(); step();
    chk("stream_rate", 64'(hs_cnt - h0), 64'd12);
    chk("stream_no_ovf", 64'(overflow), 64'd0);

    // Backpressure overflow
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(i, 20, 32'hA000_0000 + 32'(i));
    chk("bp_overflow", 64'(overflow), 64'(exp_ovf));
    chk("bp_kept", 64'(exp_q.size()), 64'd17);
    h0 = hs_cnt;
    mem_wr_ready = 1'b1;
    wait_drain(60);
    chk("bp_writes", 64'(hs_cnt - h0), 64'd17);
    clear_err = 1'b1; step(); clear_err = 1'b0; exp_ovf = 1'b0;
    chk("clear_ovf", 64'(overflow), 64'd0);

    // Clipping
    send(640, 0, 32'h1111_1111);
    send(0, 32'hFFFF_FFFF, 32'h2222_2222);
    step();
    chk("clip_flag", 64'(clip_drop), 64'(exp_clip));
    send(639, 479, 32'h3333_3333);
    step();
    chk("clip_corner_addr", 64'(mem_wr_addr), 64'(fb_base + 32'h12BFFC));
    wait_drain(20);

    // Reset mid-operation
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(i, 1, 32'h5000_0000 + 32'(i));
    step();
    chk("pre_rst_valid", 64'(mem_wr_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_flags", {59'd0, mem_wr_valid, busy, flush_done, overflow, clip_drop}, 64'd0);
    chk("midrst_addr_data", {mem_wr_addr, mem_wr_data}, 64'd0);
    exp_q.delete(); pushed = 0; hs_cnt = 0; exp_ovf = 0; exp_clip = 0;
    step();
    rst_n = 1'b1;
    mem_wr_ready = 1'b1;
    f0 = flush_cnt;
    repeat (10) step();
    chk("post_rst_writes", 64'(hs_cnt), 64'd0);
    chk("post_rst_flush", 64'(flush_cnt - f0), 64'd0);

    // Degenerate primitive
    rast_done = 1'b1; step(); rast_done = 1'b0;
    @(negedge clk); chk("nopix_flush_c1", 64'(flush_done), 64'd0);
    @(negedge clk); chk("nopix_flush_c2", 64'(flush_done), 64'd1);
    @(negedge clk); chk("nopix_flush_c3", 64'(flush_done), 64'd0);
    step();
    f0 = flush_cnt;
    rast_done = 1'b1; step(); step(); rast_done = 1'b0;
    repeat (5) step();
    chk("double_done_one_flush", 64'(flush_cnt - f0), 64'd1);

    // Randomized traffic with random stalls, including clipped pixels and address wrap
    fb_base = 32'hFFF0_0000 + ($urandom_range(0, 255) << 2);
    for (int i = 0; i < 400; i++) begin
      mem_wr_ready = ($urandom_range(0, 3) != 0);
      if ((pushed - hs_cnt) < 10 && $urandom_range(0, 1) == 1) begin
        rx = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, FB_WIDTH - 1));
        ry = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, FB_HEIGHT - 1));
        send(rx, ry, $urandom);
      end else step();
    end
    mem_wr_ready = 1'b1;
    wait_drain(60);
    chk("rand_overflow", 64'(overflow), 64'(exp_ovf));
    chk("rand_clip", 64'(clip_drop), 64'(exp_clip));
    f0 = flush_cnt;
    rast_done = 1'b1; step(); rast_done = 1'b0;
    repeat (4) step();
    chk("rand_flush", 64'(flush_cnt - f0), 64'd1);
    chk("rand_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
